tile_map_sequencer: RTL and testbench
=====================================

Name: tile_map_sequencer

Overview:
- Upstream feeder for the per-tile drawer. Walks a tile map row-major and fetches each tile index from map RAM.
- For each tile it issues a one-cycle draw request with the tile's pixel-ROM base address and screen origin, then waits for the drawer's done pulse before moving on.
- One start pulse renders one full 160x120 screen of 8x8 tiles.

Parameters:
- MAP_COLS, 20, tiles per row.
- MAP_ROWS, 15, tile rows per frame.
- MAP_BASE, 10'd0, map RAM address of tile (0,0).
- TILE_ROM_BASE, 16'd0, pixel-ROM address of tile index 0.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begin a frame
- map_address  out  10  map RAM read address
- map_data  in  8  tile index; valid one cycle after map_address is presented
- tile_address  out  16  pixel-ROM base of current tile, to drawer
- x_out  out  8  tile origin x, to drawer
- y_out  out  8  tile origin y, to drawer
- draw  out  1  one-cycle draw request, to drawer
- tile_done  in  1  one-cycle done pulse from drawer
- busy  out  1  high from first FETCH through FINISH
- frame_done  out  1  one-cycle pulse when frame complete

Behaviour:
- Reset (resetn=0 at posedge): state IDLE; col=0, row=0; map_address=MAP_BASE; tile_address=0; x_out=0; y_out=0; draw=0; busy=0; frame_done=0.
- Reset mid-frame: abandon the frame immediately with no frame_done. The drawer may still finish its tile; its later tile_done is ignored.
- States and transitions:
  - IDLE: wait for start; on start go to FETCH.
  - FETCH: drive map_address = MAP_BASE + row*MAP_COLS + col (10-bit); go to CAPTURE.
  - CAPTURE: latch map_data into idx; go to ISSUE.
  - ISSUE: draw=1 for exactly this cycle, with tile_address, x_out and y_out stable. Go to WAIT.
  - WAIT: hold tile_address, x_out, y_out. Stay until tile_done=1, then go to ADVANCE.
  - ADVANCE: col+1. When col==MAP_COLS-1, set col=0 and row+1. If the tile just drawn was (MAP_COLS-1, MAP_ROWS-1), go to FINISH; otherwise go to FETCH.
  - FINISH: frame_done=1 for one cycle; go to IDLE.
- Output arithmetic:
  - tile_address = TILE_ROM_BASE + {idx, 6'b0} (64 words per tile, 16-bit, wrap on overflow).
  - x_out = {col[4:0], 3'b0}; y_out = {row[4:0], 3'b0}.
- Outputs are registered. draw is asserted only in ISSUE, so there is never more than one outstanding request.
- start while busy: ignored.
- tile_done outside WAIT: ignored.
- tile_done in the same cycle draw is asserted: not possible by construction (the drawer needs at least 2 cycles); ignored if it occurs.
- Per-tile cost: 4 cycles plus drawer latency. Frame = 300 tiles.

Optional Feature:
- Macro: TILE_SKIP_EMPTY_EN.
- Defined: idx==8'd0 is a transparent/empty tile. From CAPTURE, go straight to ADVANCE; no draw pulse and no wait. x_out, y_out and tile_address keep their previous values.
- Undefined: index 0 is drawn like any other tile.

Decomposition:
- Shared package holds:
  - state encodings (S_IDLE..S_FINISH, 8-bit, matching the drawer's state-width style);
  - TILE_PIX = 8, TILE_WORDS = 64, SCREEN_W = 160, SCREEN_H = 120.
- One natural sub-module, tile_map_counter: the col/row counter with wrap and last-tile flag, and the map_address adder. The FSM stays in the top module.

Test Plan:
- Reset then start, with a map whose every entry is 8'd3 and a drawer model returning tile_done 5 cycles after draw.
  - First draw: tile_address=16'd192, x_out=0, y_out=0.
  - Exactly 300 draw pulses, then one frame_done; busy falls with frame_done.
- Map entry at row 1, col 19 = 8'd7.
  - Draw #40: x_out=152, y_out=8, tile_address=16'd448, map_address=10'd39.
- Hold tile_done low for 100 cycles after a draw.
  - Outputs stay frozen, draw stays 0, and no ADVANCE occurs.
- Pulse start mid-frame, and tile_done during FETCH.
  - Both ignored; tile count still 300.
- Assert resetn=0 during WAIT of tile 10.
  - Next cycle: draw=0, busy=0, map_address=MAP_BASE, no frame_done.
  - A new start renders a full frame from (0,0).
- TILE_SKIP_EMPTY_EN defined, map alternating indices 0 and 5.
  - 150 draws, all with tile_address=16'd320.
  - frame_done still asserted once.

Source files
------------

// File: rtl/tile_map_sequencer_pkg.sv
// Shared types and screen geometry for the tile map sequencer.
// State encodings use 8 bits to match the drawer's state width.
package tile_map_sequencer_pkg;

  typedef enum logic [7:0] {
    S_IDLE    = 8'd0,
    S_FETCH   = 8'd1,
    S_CAPTURE = 8'd2,
    S_ISSUE   = 8'd3,
    S_WAIT    = 8'd4,
    S_ADVANCE = 8'd5,
    S_FINISH  = 8'd6
  } state_t;

  localparam int TILE_PIX   = 8;
  localparam int TILE_WORDS = 64;
  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;

  function automatic logic [15:0] tile_base(
    input logic [15:0] rom_base,
    input logic [7:0]  idx
  );
    return rom_base + 16'(idx) * 16'(TILE_WORDS);
  endfunction

endpackage

// File: rtl/tile_map_counter.sv
// Row-major col/row walker with last-tile flag and registered
// map RAM address (MAP_BASE + row*MAP_COLS + col).
module tile_map_counter
  import tile_map_sequencer_pkg::*;
#(
  parameter int         MAP_COLS = SCREEN_W / TILE_PIX,
  parameter int         MAP_ROWS = SCREEN_H / TILE_PIX,
  parameter logic [9:0] MAP_BASE = 10'd0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       advance,
  output logic [4:0] col,
  output logic [4:0] row,
  output logic       last,
  output logic [9:0] map_address
);

  logic       col_end;
  logic [4:0] col_n;
  logic [4:0] row_n;

  assign col_end = col == 5'(MAP_COLS - 1);
  assign last    = col_end && (row == 5'(MAP_ROWS - 1));

  always_comb begin
    col_n = col + 5'd1;
    row_n = row;
    if (col_end) begin
      col_n = '0;
      row_n = last ? 5'd0 : row + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      col         <= '0;
      row         <= '0;
      map_address <= MAP_BASE;
    end else if (advance) begin
      col         <= col_n;
      row         <= row_n;
      map_address <= MAP_BASE
                   + 10'(row_n) * 10'(MAP_COLS)
                   + 10'(col_n);
    end
  end

endmodule

// File: rtl/tile_map_sequencer.sv
// Walks the tile map and issues one draw request per tile.
// TILE_SKIP_EMPTY_EN: index 0 tiles are skipped without a draw.
module tile_map_sequencer
  import tile_map_sequencer_pkg::*;
#(
  parameter int          MAP_COLS      = SCREEN_W / TILE_PIX,
  parameter int          MAP_ROWS      = SCREEN_H / TILE_PIX,
  parameter logic [9:0]  MAP_BASE      = 10'd0,
  parameter logic [15:0] TILE_ROM_BASE = 16'd0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic [9:0]  map_address,
  input  logic [7:0]  map_data,
  output logic [15:0] tile_address,
  output logic [7:0]  x_out,
  output logic [7:0]  y_out,
  output logic        draw,
  input  logic        tile_done,
  output logic        busy,
  output logic        frame_done
);

  state_t     state;
  state_t     state_n;
  logic [4:0] col;
  logic [4:0] row;
  logic       last;
  logic       skip;

`ifdef TILE_SKIP_EMPTY_EN
  assign skip = map_data == 8'd0;
`else
  assign skip = 1'b0;
`endif

  tile_map_counter #(
    .MAP_COLS (MAP_COLS),
    .MAP_ROWS (MAP_ROWS),
    .MAP_BASE (MAP_BASE)
  ) u_counter (
    .clk         (clk),
    .resetn      (resetn),
    .clear       (state == S_IDLE && start),
    .advance     (state == S_ADVANCE),
    .col         (col),
    .row         (row),
    .last        (last),
    .map_address (map_address)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:    if (start) state_n = S_FETCH;
      S_FETCH:   state_n = S_CAPTURE;
      S_CAPTURE: state_n = skip ? S_ADVANCE : S_ISSUE;
      S_ISSUE:   state_n = S_WAIT;
      S_WAIT:    if (tile_done) state_n = S_ADVANCE;
      S_ADVANCE: state_n = last ? S_FINISH : S_FETCH;
      S_FINISH:  state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  // Flags are decoded from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tile_address <= '0;
      x_out        <= '0;
      y_out        <= '0;
      draw         <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      draw       <= state_n == S_ISSUE;
      busy       <= state_n != S_IDLE;
      frame_done <= state_n == S_FINISH;
      if (state == S_CAPTURE && !skip) begin
        tile_address <= tile_base(TILE_ROM_BASE, map_data);
        x_out        <= {col, 3'b000};
        y_out        <= {row, 3'b000};
      end
    end
  end

endmodule

// File: tb/tb_tile_map_sequencer.sv
// Scoreboard bench: expected draws are queued at frame start and
// popped by a monitor on each draw pulse.
module tb_tile_map_sequencer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        tile_done = 1'b0;
  logic [7:0]  map_data;
  logic [9:0]  map_address;
  logic [15:0] tile_address;
  logic [7:0]  x_out;
  logic [7:0]  y_out;
  logic        draw;
  logic        busy;
  logic        frame_done;

  typedef struct packed {
    logic [15:0] ta;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [9:0]  ma;
  } rec_t;

`ifdef TILE_SKIP_EMPTY_EN
  localparam int EXP_DRAWS = 150;
`else
  localparam int EXP_DRAWS = 300;
`endif

  logic [7:0] mem [0:1023];
  rec_t       q[$];
  rec_t       first_rec;
  rec_t       rec40;
  int         total = 0;
  int         bad = 0;
  int         draws = 0;
  int         frames = 0;
  int         stall_at = -1;
  logic       prev_fd = 1'b0;

  always #5 clk = ~clk;

  tile_map_sequencer dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .map_address  (map_address),
    .map_data     (map_data),
    .tile_address (tile_address),
    .x_out        (x_out),
    .y_out        (y_out),
    .draw         (draw),
    .tile_done    (tile_done),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  // Synchronous map RAM: data one cycle after the address.
  always @(posedge clk) map_data <= mem[map_address];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic load_expect();
    rec_t r;
    int   i;
    q.delete();
    for (int ro = 0; ro < 15; ro++) begin
      for (int co = 0; co < 20; co++) begin
        i = ro * 20 + co;
`ifdef TILE_SKIP_EMPTY_EN
        if (mem[i] == 8'd0) continue;
`endif
        r.ta = 16'(mem[i]) * 16'd64;
        r.x  = 8'(co * 8);
        r.y  = 8'(ro * 8);
        r.ma = 10'(i);
        q.push_back(r);
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_frame(input string nm);
    int c = 0;
    while (frames == 0 && c < 20000) begin
      tick();
      c++;
    end
    chk(nm, 32'(frames != 0), 32'd1);
  endtask

  // Monitor: pops the scoreboard on every draw pulse.
  always @(negedge clk) begin : monitor
    rec_t e;
    if (draw) begin
      draws++;
      if (draws == 1)  first_rec = {tile_address, x_out, y_out, map_address};
      if (draws == 40) rec40     = {tile_address, x_out, y_out, map_address};
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL draw_extra: got draw %0d expected none", draws);
      end else begin
        e = q.pop_front();
        chk("draw_tile_address", 32'(tile_address), 32'(e.ta));
        chk("draw_x_out", 32'(x_out), 32'(e.x));
        chk("draw_y_out", 32'(y_out), 32'(e.y));
        chk("draw_map_address", 32'(map_address), 32'(e.ma));
      end
    end
    if (frame_done) begin
      frames++;
      chk("busy_at_frame_done", 32'(busy), 32'd1);
    end
    if (prev_fd) begin
      chk("busy_after_frame_done", 32'(busy), 32'd0);
      chk("frame_done_one_cycle", 32'(frame_done), 32'd0);
    end
    prev_fd = frame_done;
  end

  // Drawer model: done 5 cycles after draw, then a stray done in FETCH.
  initial begin : drawer
    int          lat;
    logic [15:0] s_ta;
    logic [7:0]  s_x;
    logic [7:0]  s_y;
    logic [9:0]  s_ma;
    int          s_n;
    forever begin
      tick();
      if (draw) begin
        lat  = (draws == stall_at) ? 100 : 5;
        s_ta = tile_address;
        s_x  = x_out;
        s_y  = y_out;
        s_ma = map_address;
        s_n  = draws;
        repeat (lat) @(posedge clk);
        #1;
        if (lat == 100) begin
          chk("stall_tile_address", 32'(tile_address), 32'(s_ta));
          chk("stall_x_out", 32'(x_out), 32'(s_x));
          chk("stall_y_out", 32'(y_out), 32'(s_y));
          chk("stall_map_address", 32'(map_address), 32'(s_ma));
          chk("stall_no_draw", 32'(draws), 32'(s_n));
          chk("stall_draw_low", 32'(draw), 32'd0);
        end
        tile_done = 1'b1;
        @(posedge clk);
        #1 tile_done = 1'b0;
        @(posedge clk);
        #1 tile_done = 1'b1;
        @(posedge clk);
        #1 tile_done = 1'b0;
      end
    end
  end

  initial begin : stim
    int c;
    for (int i = 0; i < 1024; i++) mem[i] = 8'd3;
    mem[39] = 8'd7;
`ifdef TILE_SKIP_EMPTY_EN
    for (int i = 0; i < 1024; i++) mem[i] = (i % 2 == 1) ? 8'd5 : 8'd0;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_draw", 32'(draw), 32'd0);
    chk("reset_frame_done", 32'(frame_done), 32'd0);
    chk("reset_map_address", 32'(map_address), 32'd0);
    chk("reset_tile_address", 32'(tile_address), 32'd0);
    chk("reset_x_out", 32'(x_out), 32'd0);
    chk("reset_y_out", 32'(y_out), 32'd0);
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Full frame with a stalled drawer and a stray mid-frame start.
    stall_at = 3;
    draws = 0;
    frames = 0;
    load_expect();
    pulse_start();
    repeat (200) @(posedge clk);
    #1;
    chk("busy_mid_frame", 32'(busy), 32'd1);
    pulse_start();
    wait_frame("frame1_timeout");
    repeat (50) tick();
    chk("frame1_draws", 32'(draws), 32'(EXP_DRAWS));
    chk("frame1_frames", 32'(frames), 32'd1);
    chk("frame1_queue_empty", 32'(q.size()), 32'd0);
    chk("frame1_idle", 32'(busy), 32'd0);
`ifdef TILE_SKIP_EMPTY_EN
    chk("first_tile_address", 32'(first_rec.ta), 32'd320);
    chk("first_x_out", 32'(first_rec.x), 32'd8);
    chk("first_y_out", 32'(first_rec.y), 32'd0);
`else
    chk("first_tile_address", 32'(first_rec.ta), 32'd192);
    chk("first_x_out", 32'(first_rec.x), 32'd0);
    chk("first_y_out", 32'(first_rec.y), 32'd0);
    chk("draw40_x_out", 32'(rec40.x), 32'd152);
    chk("draw40_y_out", 32'(rec40.y), 32'd8);
    chk("draw40_tile_address", 32'(rec40.ta), 32'd448);
    chk("draw40_map_address", 32'(rec40.ma), 32'd39);
`endif
    stall_at = -1;

    // Reset while waiting on the tenth tile.
    draws = 0;
    frames = 0;
    load_expect();
    pulse_start();
    c = 0;
    while (draws < 10 && c < 4000) begin
      tick();
      c++;
    end
    chk("reach_tile10", 32'(draws >= 10), 32'd1);
    @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_draw", 32'(draw), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_map_address", 32'(map_address), 32'd0);
    chk("midreset_frame_done", 32'(frame_done), 32'd0);
    resetn = 1'b1;
    q.delete();
    repeat (30) tick();
    chk("midreset_no_frame", 32'(frames), 32'd0);
    chk("midreset_still_idle", 32'(busy), 32'd0);

    // Fresh frame after the abandoned one.
    draws = 0;
    frames = 0;
    load_expect();
    pulse_start();
    wait_frame("frame2_timeout");
    repeat (20) tick();
    chk("frame2_draws", 32'(draws), 32'(EXP_DRAWS));
    chk("frame2_frames", 32'(frames), 32'd1);
    chk("frame2_queue_empty", 32'(q.size()), 32'd0);
`ifdef TILE_SKIP_EMPTY_EN
    chk("frame2_first_ta", 32'(first_rec.ta), 32'd320);
`else
    chk("frame2_first_ta", 32'(first_rec.ta), 32'd192);
    chk("frame2_first_x", 32'(first_rec.x), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
